// File: rtl/rv32i_types.sv
// Shared types and sizing for the retirement RAT.
// Holds the superscalar width, physical and architectural tag widths, and the
// phys_reg / arch_reg tag types that the RRAT ports use.
package rv32i_types;

    localparam int unsigned SS_FACTOR          = 4;
    localparam int unsigned SS_FACTOR_BITS     = 2;
    localparam int unsigned NUM_PHYS_REGS      = 64;
    localparam int unsigned NUM_PHYS_REGS_BITS = 6;
    localparam int unsigned ARCH_REG_BITS      = 5;
    localparam int unsigned NUM_ARCH           = 32;

    // Short aliases used by the RRAT.
    localparam int unsigned SS        = SS_FACTOR;
    localparam int unsigned SS_BITS   = SS_FACTOR_BITS;
    localparam int unsigned PHYS_BITS = NUM_PHYS_REGS_BITS;

    typedef logic [PHYS_BITS-1:0]     phys_reg;
    typedef logic [ARCH_REG_BITS-1:0] arch_reg;
    typedef logic [SS_BITS:0]         push_cnt;

endpackage

// File: rtl/rrat_lane_resolve.sv
// Combinational lane resolution for one commit group.
// Ports:
//   commit_valid/commit_regwrite/commit_rd/commit_pd - the commit group
//   map          - committed map before this group
//   effective_c  - lane updates the map and frees a tag
//   old_tag_c    - tag displaced by each lane, with same-rd forwarding
//   slot_c       - compacted freed_register position of each lane
//   push_count_c - number of effective lanes
module rrat_lane_resolve
    import rv32i_types::*;
(
    input  logic    [SS-1:0]               commit_valid,
    input  logic    [SS-1:0]               commit_regwrite,
    input  arch_reg [SS-1:0]               commit_rd,
    input  phys_reg [SS-1:0]               commit_pd,
    input  phys_reg [NUM_ARCH-1:0]         map,
    output logic    [SS-1:0]               effective_c,
    output phys_reg [SS-1:0]               old_tag_c,
    output logic    [SS-1:0][SS_BITS-1:0]  slot_c,
    output push_cnt                        push_count_c
);

    // Old tag comes from the latest lower effective lane with the same rd,
    // falling back to the committed map; slots are a running prefix count.
    always_comb begin
        effective_c  = '0;
        old_tag_c    = '0;
        slot_c       = '0;
        push_count_c = '0;
        for (int i = 0; i < int'(SS); i++) begin
            effective_c[i] = commit_valid[i] & commit_regwrite[i]
                             & (commit_rd[i] != '0);
        end
        for (int i = 0; i < int'(SS); i++) begin
            old_tag_c[i] = map[commit_rd[i]];
            for (int j = 0; j < int'(SS); j++) begin
                if ((j < i) && effective_c[j] && (commit_rd[j] == commit_rd[i])) begin
                    old_tag_c[i] = commit_pd[j];
                end
            end
            slot_c[i] = push_count_c[SS_BITS-1:0];
            if (effective_c[i]) begin
                push_count_c = push_cnt'(push_count_c + 1'b1);
            end
        end
    end

endmodule

// File: rtl/retirement_rat.sv
// Retirement register alias table.
// Records committed arch->phys mappings and returns each displaced physical
// tag to the free list one cycle later, compacted into the low lanes.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   commit_valid    - per-lane commit strobe (contiguous from lane 0)
//   commit_regwrite - lane writes a destination register
//   commit_rd       - architectural destination per lane
//   commit_pd       - physical destination per lane
//   freed_register  - displaced tags, compacted (registered)
//   rrf_push        - count of valid freed_register lanes (registered)
//   rrat_map        - committed arch->phys map (registered)
//   rrat_err        - sticky consistency error, only with RRAT_CHECK_EN
// Build option: define RRAT_CHECK_EN to add the mapped-tag bitmap and rrat_err.
module retirement_rat
    import rv32i_types::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic    [SS-1:0]       commit_valid,
    input  logic    [SS-1:0]       commit_regwrite,
    input  arch_reg [SS-1:0]       commit_rd,
    input  phys_reg [SS-1:0]       commit_pd,
    output phys_reg [SS-1:0]       freed_register,
    output push_cnt                rrf_push,
    output phys_reg [NUM_ARCH-1:0] rrat_map
`ifdef RRAT_CHECK_EN
    ,
    output logic                   rrat_err
`endif
);

    logic    [SS-1:0]              effective_c;
    phys_reg [SS-1:0]              old_tag_c;
    logic    [SS-1:0][SS_BITS-1:0] slot_c;
    push_cnt                       push_count_c;
    phys_reg [NUM_ARCH-1:0]        map_next_c;
    phys_reg [SS-1:0]              freed_next_c;

    rrat_lane_resolve u_resolve (
        .commit_valid    (commit_valid),
        .commit_regwrite (commit_regwrite),
        .commit_rd       (commit_rd),
        .commit_pd       (commit_pd),
        .map             (rrat_map),
        .effective_c     (effective_c),
        .old_tag_c       (old_tag_c),
        .slot_c          (slot_c),
        .push_count_c    (push_count_c)
    );

    // Apply lanes in program order so the highest same-rd lane wins.
    always_comb begin
        map_next_c   = rrat_map;
        freed_next_c = '0;
        for (int i = 0; i < int'(SS); i++) begin
            if (effective_c[i]) begin
                map_next_c[commit_rd[i]] = commit_pd[i];
                freed_next_c[slot_c[i]]  = old_tag_c[i];
            end
        end
    end

    // Map and freed-tag registers; reset restores the identity map.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ARCH); i++) begin
                rrat_map[i] <= phys_reg'(i);
            end
            freed_register <= '0;
            rrf_push       <= '0;
        end else begin
            rrat_map       <= map_next_c;
            freed_register <= freed_next_c;
            rrf_push       <= push_count_c;
        end
    end

`ifdef RRAT_CHECK_EN
    logic [NUM_PHYS_REGS-1:0] mapped;
    logic [NUM_PHYS_REGS-1:0] mapped_next_c;
    logic                     err_next_c;

    // Walk lanes in order: a new pd must be unmapped, a freed tag must be mapped.
    always_comb begin
        mapped_next_c = mapped;
        err_next_c    = 1'b0;
        for (int i = 0; i < int'(SS); i++) begin
            if (effective_c[i]) begin
                if (mapped_next_c[commit_pd[i]]) begin
                    err_next_c = 1'b1;
                end
                if (!mapped_next_c[old_tag_c[i]]) begin
                    err_next_c = 1'b1;
                end
                mapped_next_c[old_tag_c[i]] = 1'b0;
                mapped_next_c[commit_pd[i]] = 1'b1;
            end
        end
    end

    // Bitmap starts with the identity-mapped tags 0..31 live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mapped   <= {{(NUM_PHYS_REGS-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
            rrat_err <= 1'b0;
        end else begin
            mapped   <= mapped_next_c;
            rrat_err <= rrat_err | err_next_c;
        end
    end
`endif

endmodule

// File: tb/tb_retirement_rat.sv
// Self-checking bench for retirement_rat: directed vector table, reset and
// back-to-back sequences, then random commit groups against an array model.
module tb_retirement_rat;
    import rv32i_types::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic    [SS-1:0]       commit_valid;
    logic    [SS-1:0]       commit_regwrite;
    arch_reg [SS-1:0]       commit_rd;
    phys_reg [SS-1:0]       commit_pd;
    phys_reg [SS-1:0]       freed_register;
    push_cnt                rrf_push;
    phys_reg [NUM_ARCH-1:0] rrat_map;
`ifdef RRAT_CHECK_EN
    logic                   rrat_err;
`endif

    retirement_rat dut (
        .clk             (clk),
        .rst             (rst),
        .commit_valid    (commit_valid),
        .commit_regwrite (commit_regwrite),
        .commit_rd       (commit_rd),
        .commit_pd       (commit_pd),
        .freed_register  (freed_register),
        .rrf_push        (rrf_push),
        .rrat_map        (rrat_map)
`ifdef RRAT_CHECK_EN
        ,
        .rrat_err        (rrat_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        string      name;
        logic [3:0] valid;
        logic [3:0] wr;
        int         rd[4];
        int         pd[4];
        int         push;
        int         freed[4];
        int         map_idx;
        int         map_val;
    } vec_t;

    function automatic vec_t mk(input string n, input int nv, input logic [3:0] w,
                                input int r0, input int r1, input int r2, input int r3,
                                input int p0, input int p1, input int p2, input int p3,
                                input int push,
                                input int f0, input int f1, input int f2, input int f3,
                                input int mi, input int mv);
        vec_t v;
        v.name  = n;
        v.valid = 4'((1 << nv) - 1);
        v.wr    = w;
        v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2; v.rd[3] = r3;
        v.pd[0] = p0; v.pd[1] = p1; v.pd[2] = p2; v.pd[3] = p3;
        v.push  = push;
        v.freed[0] = f0; v.freed[1] = f1; v.freed[2] = f2; v.freed[3] = f3;
        v.map_idx = mi;
        v.map_val = mv;
        return v;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0] w,
                         input int rd[4], input int pd[4]);
        commit_valid    = v;
        commit_regwrite = w;
        for (int l = 0; l < 4; l++) begin
            commit_rd[l] = arch_reg'(rd[l]);
            commit_pd[l] = phys_reg'(pd[l]);
        end
    endtask

    task automatic idle();
        commit_valid    = '0;
        commit_regwrite = '0;
        commit_rd       = '0;
        commit_pd       = '0;
    endtask

    task automatic check_identity(input string name);
        int bad = 0;
        for (int i = 0; i < 32; i++) if (int'(rrat_map[i]) != i) bad++;
        check(name, bad, 0);
    endtask

    vec_t vecs[10];
    int   mm[32];
    int   fq[$];

    initial begin
        rst = 1'b1;
        idle();

        // Directed table; each row assumes the state left by the rows above.
        vecs[0] = mk("single",      1, 4'b0001,  3, 0, 0, 0, 40,  0,  0,  0, 1,  3,  0,  0, 0,  3, 40);
        vecs[1] = mk("same_rd",     2, 4'b0011,  5, 5, 0, 0, 41, 42,  0,  0, 2,  5, 41,  0, 0,  5, 42);
        vecs[2] = mk("compact_rd0", 2, 4'b0011,  0, 9, 0, 0, 43, 50,  0,  0, 1,  9,  0,  0, 0,  0,  0);
        vecs[3] = mk("compact_wr",  2, 4'b0010,  7,10, 0, 0, 44, 51,  0,  0, 1, 10,  0,  0, 0,  7,  7);
        vecs[4] = mk("b2b_a",       1, 4'b0001,  4, 0, 0, 0, 33,  0,  0,  0, 1,  4,  0,  0, 0,  4, 33);
        vecs[5] = mk("b2b_b",       1, 4'b0001,  4, 0, 0, 0, 34,  0,  0,  0, 1, 33,  0,  0, 0,  4, 34);
        vecs[6] = mk("idle",        0, 4'b0000,  0, 0, 0, 0,  0,  0,  0,  0, 0,  0,  0,  0, 0,  4, 34);
        vecs[7] = mk("four_lane",   4, 4'b1111,  1, 2, 1, 6, 35, 36, 37, 38, 4,  1,  2, 35, 6,  1, 37);
        vecs[8] = mk("mixed",       3, 4'b0101, 11,12,13, 0, 39, 45, 46,  0, 2, 11, 13,  0, 0, 12, 12);
        vecs[9] = mk("valid_gate",  0, 4'b1111, 14, 0, 0, 0, 47,  0,  0,  0, 0,  0,  0,  0, 0, 14, 14);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_identity("reset_map");
        check("reset_push", int'(rrf_push), 0);
        check("reset_freed", int'(freed_register), 0);
        @(negedge clk);
        check("post_reset_map7", int'(rrat_map[7]), 7);
        check("post_reset_push", int'(rrf_push), 0);

        foreach (vecs[k]) begin
            drive(vecs[k].valid, vecs[k].wr, vecs[k].rd, vecs[k].pd);
            @(negedge clk);
            check($sformatf("%s push", vecs[k].name), int'(rrf_push), vecs[k].push);
            for (int l = 0; l < 4; l++)
                check($sformatf("%s freed%0d", vecs[k].name, l),
                      int'(freed_register[l]), vecs[k].freed[l]);
            check($sformatf("%s map[%0d]", vecs[k].name, vecs[k].map_idx),
                  int'(rrat_map[vecs[k].map_idx]), vecs[k].map_val);
        end
        check("map9_after_table", int'(rrat_map[9]), 50);
        check("map0_after_table", int'(rrat_map[0]), 0);

        // Reset lands while a group is presented; the group must be dropped.
        begin
            int rd_m[4] = '{7, 8, 0, 0};
            int pd_m[4] = '{60, 61, 0, 0};
            drive(4'b0011, 4'b0011, rd_m, pd_m);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("midrst_map7", int'(rrat_map[7]), 7);
        check("midrst_push", int'(rrf_push), 0);
        check_identity("midrst_map");
        @(negedge clk);
        check("midrst_map8_later", int'(rrat_map[8]), 8);
        check("midrst_push_later", int'(rrf_push), 0);

        // Random groups against an in-order array model and a FIFO free list.
        for (int i = 0; i < 32; i++) mm[i] = i;
        fq.delete();
        for (int t = 32; t < 64; t++) fq.push_back(t);
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [3:0] v, w;
            int rd[4], pd[4], ef[4];
            int nv, k, bad;
            nv = int'($urandom_range(0, 4));
            k  = 0;
            for (int l = 0; l < 4; l++) begin
                v[l]  = (l < nv);
                w[l]  = ($urandom_range(0, 3) != 0);
                rd[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                    : int'($urandom_range(0, 5));
                if (v[l] && w[l] && rd[l] != 0) pd[l] = fq.pop_front();
                else pd[l] = int'($urandom_range(0, 63));
                ef[l] = 0;
            end
            for (int l = 0; l < 4; l++) begin
                if (v[l] && w[l] && rd[l] != 0) begin
                    ef[k] = mm[rd[l]];
                    mm[rd[l]] = pd[l];
                    k++;
                end
            end
            for (int l = 0; l < k; l++) fq.push_back(ef[l]);
            drive(v, w, rd, pd);
            @(negedge clk);
            check($sformatf("rand%0d push", cyc), int'(rrf_push), k);
            for (int l = 0; l < 4; l++)
                check($sformatf("rand%0d freed%0d", cyc, l), int'(freed_register[l]), ef[l]);
            bad = 0;
            for (int i = 0; i < 32; i++) if (int'(rrat_map[i]) != mm[i]) bad++;
            check($sformatf("rand%0d map_diffs", cyc), bad, 0);
        end
        idle();

`ifdef RRAT_CHECK_EN
        check("err_clean_run", int'(rrat_err), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            int rd_a[4] = '{3, 0, 0, 0};
            int rd_b[4] = '{6, 0, 0, 0};
            int pd_a[4] = '{40, 0, 0, 0};
            drive(4'b0001, 4'b0001, rd_a, pd_a);
            @(negedge clk);
            check("err_first_commit", int'(rrat_err), 0);
            drive(4'b0001, 4'b0001, rd_b, pd_a);
            @(negedge clk);
            check("err_dup_pd", int'(rrat_err), 1);
        end
        idle();
        @(negedge clk);
        check("err_sticky", int'(rrat_err), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_cleared_by_rst", int'(rrat_err), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
